// File: rtl/uart_pkt_scheduler.sv
// Two-requester packet scheduler for a byte-wide UART serializer.
// Each granted 64-bit word is sent as: header, 8 data bytes (LSB first), XOR checksum.
module uart_pkt_scheduler #(
  parameter logic [7:0] HDR0    = 8'hA5,
  parameter logic [7:0] HDR1    = 8'h5A,
  parameter int         GAP_CYC = 16,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_m,
  input  logic             req0_valid,
  input  logic [63:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [63:0]      req1_data,
  output logic             req1_ready,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_byte,
  output logic             pkt_active,
  output logic             pkt_src,
  output logic [CNT_W-1:0] sent_count,
  output logic             tx_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int         GW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [2:0] ACK_TO = 3'd7;
  localparam logic [3:0] IDX_CS = 4'd9;

  logic [2:0]    state;
  logic [3:0]    idx;
  logic [2:0]    ack_cnt;
  logic [GW-1:0] gap_cnt;
  logic [63:0]   word;
  logic [7:0]    csum;
  logic          last_src;

  logic          gnt_any;
  logic          gnt_src;
  logic          grant;
  logic [7:0]    nxt_byte;

  // Tie goes to the requester that was not served last.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_src = (req0_valid & req1_valid) ? ~last_src : req1_valid;
  assign grant   = rst_m & (state == S_IDLE) & gnt_any;

  assign req0_ready = grant & ~gnt_src;
  assign req1_ready = grant &  gnt_src;

  // tx_byte is preloaded on entry to SEND, so the strobe only has to wait for an idle serializer.
  assign tx_start = (state == S_SEND) & ~tx_busy;

  // Byte for index idx+1: data byte idx while idx<8, then the accumulated checksum.
  assign nxt_byte = (idx == 4'd8) ? csum : word[{idx[2:0], 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_m) begin
    if (!rst_m) begin
      state      <= S_IDLE;
      idx        <= '0;
      ack_cnt    <= '0;
      gap_cnt    <= '0;
      word       <= '0;
      csum       <= '0;
      last_src   <= 1'b1;
      tx_byte    <= '0;
      pkt_active <= 1'b0;
      pkt_src    <= 1'b0;
      sent_count <= '0;
      tx_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            word       <= gnt_src ? req1_data : req0_data;
            pkt_src    <= gnt_src;
            last_src   <= gnt_src;
            pkt_active <= 1'b1;
            idx        <= '0;
            csum       <= gnt_src ? HDR1 : HDR0;
            tx_byte    <= gnt_src ? HDR1 : HDR0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            if (idx != 4'd0 && idx != IDX_CS) csum <= csum ^ tx_byte;
            ack_cnt <= '0;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          // A serializer that never answers is flagged, and the byte counted as sent.
          if (tx_busy) begin
            state <= S_DRAIN;
          end else if (ack_cnt == ACK_TO) begin
            tx_err <= 1'b1;
            state  <= S_DRAIN;
          end else begin
            ack_cnt <= ack_cnt + 3'd1;
          end
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            if (idx == IDX_CS) begin
              sent_count <= sent_count + {{(CNT_W-1){1'b0}}, 1'b1};
              gap_cnt    <= '0;
              pkt_active <= (GAP_CYC != 0);
              state      <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
            end else begin
              idx     <= idx + 4'd1;
              tx_byte <= nxt_byte;
              state   <= S_SEND;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            pkt_active <= 1'b0;
            state      <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + {{(GW-1){1'b0}}, 1'b1};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
